// File: rtl/alu_control_seq.sv
// Purpose: registered ALU control decoder; {ALUOp, OpCode, Funct} -> CTRL_W control word, illegal flag, MUL/DIV flag.
// Latency: 1 cycle from accept to out_valid; a single output register allows back-to-back streaming with no bubble.
// Backpressure: in_ready = out_ready && !multi_cycle while full; a handed-off MUL/DIV stalls issue for MC_LATENCY cycles.
module alu_control_seq #(
    parameter int ALUOP_W    = 2,
    parameter int OP_W       = 6,
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 4,
    parameter int MC_LATENCY = 4,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [OP_W-1:0]    OpCode,
    input  logic [FUNCT_W-1:0] Funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               multi_cycle,
    output logic               illegal,
    output logic               busy,
    output logic [ERR_W-1:0]   err_count
);

    // Stall counter only needs to hold MC_LATENCY-1.
    localparam int CNT_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Op classes carried on ALUOp.
    localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] AOP_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] AOP_RTYPE = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] AOP_ITYPE = ALUOP_W'(2'b11);

    // R-type function codes.
    localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100001);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100011);
    localparam logic [FUNCT_W-1:0] F_SLL = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SRL = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] F_SRA = FUNCT_W'(6'b101000);
    localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101001);
    localparam logic [FUNCT_W-1:0] F_MUL = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_DIV = FUNCT_W'(6'b101011);

    // I-type opcodes.
    localparam logic [OP_W-1:0] O_ANDI = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] O_ADDI = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] O_ORI  = OP_W'(6'b110011);
    localparam logic [OP_W-1:0] O_SLTI = OP_W'(6'b110100);

    // ALU control codes, zero-extended to CTRL_W.
    localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] C_SRA = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] C_DIV = CTRL_W'(4'b1011);
    localparam logic [CTRL_W-1:0] C_ILL = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_mc;
    logic               r_ill;
    logic [ERR_W-1:0]   r_err;

    logic [CTRL_W-1:0]  w_dec_ctrl;
    logic               w_dec_mc;
    logic               w_dec_ill;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_handoff;

    // Decode the incoming fields; anything unmatched falls through as illegal.
    always_comb begin
        w_dec_ctrl = C_ILL;
        w_dec_mc   = 1'b0;
        w_dec_ill  = 1'b1;
        case (ALUOp)
            AOP_ADD: begin
                w_dec_ctrl = C_ADD;
                w_dec_ill  = 1'b0;
            end
            AOP_SUB: begin
                w_dec_ctrl = C_SUB;
                w_dec_ill  = 1'b0;
            end
            AOP_RTYPE: begin
                case (Funct)
                    F_AND: begin w_dec_ctrl = C_AND; w_dec_ill = 1'b0; end
                    F_ADD: begin w_dec_ctrl = C_ADD; w_dec_ill = 1'b0; end
                    F_SUB: begin w_dec_ctrl = C_SUB; w_dec_ill = 1'b0; end
                    F_OR:  begin w_dec_ctrl = C_OR;  w_dec_ill = 1'b0; end
                    F_SLL: begin w_dec_ctrl = C_SLL; w_dec_ill = 1'b0; end
                    F_SRL: begin w_dec_ctrl = C_SRL; w_dec_ill = 1'b0; end
                    F_SRA: begin w_dec_ctrl = C_SRA; w_dec_ill = 1'b0; end
                    F_SLT: begin w_dec_ctrl = C_SLT; w_dec_ill = 1'b0; end
                    F_MUL: begin w_dec_ctrl = C_MUL; w_dec_ill = 1'b0; w_dec_mc = 1'b1; end
                    F_DIV: begin w_dec_ctrl = C_DIV; w_dec_ill = 1'b0; w_dec_mc = 1'b1; end
                    default: ;
                endcase
            end
            AOP_ITYPE: begin
                case (OpCode)
                    O_ANDI: begin w_dec_ctrl = C_AND; w_dec_ill = 1'b0; end
                    O_ADDI: begin w_dec_ctrl = C_ADD; w_dec_ill = 1'b0; end
                    O_ORI:  begin w_dec_ctrl = C_OR;  w_dec_ill = 1'b0; end
                    O_SLTI: begin w_dec_ctrl = C_SLT; w_dec_ill = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Next-state and in_ready; a held MUL/DIV blocks issue so the stall can follow its handoff.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                w_in_ready = out_ready && !r_mc;
                if (out_ready) begin
                    if (r_mc) begin
                        w_next_state = ST_STALL;
                    end else if (in_valid) begin
                        w_next_state = ST_FULL;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_STALL: begin
                if (r_stall_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && w_in_ready;
    assign w_handoff = (r_state == ST_FULL) && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stall counter: loaded on a multi-cycle handoff, counts down to zero while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_handoff && r_mc) begin
            r_stall_cnt <= CNT_LOAD;
        end else if ((r_state == ST_STALL) && (r_stall_cnt != '0)) begin
            r_stall_cnt <= r_stall_cnt - CNT_W'(1);
        end
    end

    // Output register: captures the decoded op on accept, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
            r_mc   <= 1'b0;
            r_ill  <= 1'b0;
        end else if (w_accept) begin
            r_ctrl <= w_dec_ctrl;
            r_mc   <= w_dec_mc;
            r_ill  <= w_dec_ill;
        end
    end

    // Saturating count of accepted illegal encodings.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_accept && w_dec_ill && (r_err != ERR_MAX)) begin
            r_err <= r_err + ERR_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == ST_FULL);
    assign busy        = (r_state == ST_STALL);
    assign alu_ctrl    = r_ctrl;
    assign multi_cycle = r_mc;
    assign illegal     = r_ill;
    assign err_count   = r_err;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs change on the falling edge; outputs are compared on the falling edge, away from the rising edge.
// The model tracks slot occupancy and remaining stall cycles rather than any FSM encoding.
module tb_alu_control_seq;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] ALUOp = 2'b00;
    logic [5:0] OpCode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_ctrl;
    logic       multi_cycle;
    logic       illegal;
    logic       busy;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    bit       m_full;
    bit [3:0] m_ctrl;
    bit       m_mc;
    bit       m_ill;
    int       m_stall;
    int       m_err;

    logic [5:0] i_opc  [4] = '{6'b110000, 6'b110001, 6'b110011, 6'b110100};
    logic [3:0] i_code [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1001};

    alu_control_seq #(
        .ALUOP_W(2), .OP_W(6), .FUNCT_W(6), .CTRL_W(4), .MC_LATENCY(MC), .ERR_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .OpCode(OpCode), .Funct(Funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .multi_cycle(multi_cycle), .illegal(illegal),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // R-type codes are the Funct value minus 6'b100000 for the defined set.
    function automatic void ref_decode(input logic [1:0] aop, input logic [5:0] opc, input logic [5:0] fn,
                                       output bit [3:0] c, output bit mc, output bit ill);
        int f;
        f = int'(fn);
        c = 4'hF; mc = 1'b0; ill = 1'b1;
        case (aop)
            2'b00: begin c = 4'b0001; ill = 1'b0; end
            2'b01: begin c = 4'b0010; ill = 1'b0; end
            2'b10: if (f inside {32, 33, 34, 35, 37, 38, 40, 41, 42, 43}) begin
                c = 4'(f - 32); ill = 1'b0; mc = (f >= 42);
            end
            default: for (int i = 0; i < 4; i++) if (opc == i_opc[i]) begin c = i_code[i]; ill = 1'b0; end
        endcase
    endfunction

    function automatic bit exp_ready();
        if (m_stall > 0) return 1'b0;
        if (!m_full) return 1'b1;
        return out_ready && !m_mc;
    endfunction

    task automatic model_reset();
        m_full = 0; m_ctrl = 0; m_mc = 0; m_ill = 0; m_stall = 0; m_err = 0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_step();
        bit acc, hand, dmc, dill;
        bit [3:0] dc;
        acc  = in_valid && exp_ready();
        hand = m_full && out_ready;
        ref_decode(ALUOp, OpCode, Funct, dc, dmc, dill);
        if (m_stall > 0) m_stall--;
        if (hand && m_mc) begin
            m_full = 0; m_stall = MC;
        end else if (acc) begin
            m_full = 1; m_ctrl = dc; m_mc = dmc; m_ill = dill;
        end else if (hand) begin
            m_full = 0;
        end
        if (acc && dill && m_err < 255) m_err++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (alu_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_alu_ctrl: got %h want 0", alu_ctrl); end
        n_tests++; if ({multi_cycle, illegal, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {multi_cycle, illegal, busy}); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b100110; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_tests++; if (alu_ctrl !== 4'b0110) begin n_fail++; $display("FAIL single_ctrl: got %b want 0110", alu_ctrl); end
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL single_illegal: got %b want 0", illegal); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] aops [3] = '{2'b00, 2'b01, 2'b11};
        logic [3:0] exps [3] = '{4'b0001, 4'b0010, 4'b0001};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; ALUOp = aops[i]; OpCode = 6'b110001; #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_tests++; if (out_valid !== 1'b1 || alu_ctrl !== exps[i]) begin
                n_fail++; $display("FAIL b2b_ctrl[%0d]: got v=%b %b want v=1 %b", i, out_valid, alu_ctrl, exps[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b101001; out_ready = 1'b0;
        tick();
        ALUOp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (alu_ctrl !== 4'b1001 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %b want v=1 1001", i, out_valid, alu_ctrl);
            end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0001) begin
            n_fail++; $display("FAIL bp_next_op: got v=%b %b want v=1 0001", out_valid, alu_ctrl);
        end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_multi_cycle();
        in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b101010; out_ready = 1'b1;
        tick();
        ALUOp = 2'b00; #1;
        n_tests++; if (alu_ctrl !== 4'b1010 || multi_cycle !== 1'b1) begin
            n_fail++; $display("FAIL mc_decode: got %b mc=%b want 1010 mc=1", alu_ctrl, multi_cycle);
        end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mc_hold_ready: got %b want 0", in_ready); end
        tick();
        for (int i = 0; i < MC; i++) begin
            #1;
            n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL mc_stall[%0d]: got busy=%b rdy=%b v=%b want 1 0 0", i, busy, in_ready, out_valid);
            end
            tick();
        end
        #1;
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mc_end: got busy=%b rdy=%b want 0 1", busy, in_ready);
        end
        tick();
        in_valid = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0001) begin
            n_fail++; $display("FAIL mc_after: got v=%b %b want v=1 0001", out_valid, alu_ctrl);
        end
        tick();
    endtask

    task automatic test_illegal();
        int want;
        out_ready = 1'b1; in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b000000;
        for (int i = 0; i < 300; i++) begin
            tick();
            want = (i + 1 > 255) ? 255 : i + 1;
            n_tests++; if (alu_ctrl !== 4'b1111 || illegal !== 1'b1 || int'(err_count) != want) begin
                n_fail++; $display("FAIL illegal[%0d]: got %b ill=%b err=%0d want 1111 ill=1 err=%0d", i, alu_ctrl, illegal, err_count, want);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_stall();
        in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b101011; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_stall_busy: got %b want 1", busy); end
        reset = 1'b1; #1;
        n_tests++; if ({out_valid, busy, multi_cycle, illegal} !== 4'b0000 || alu_ctrl !== 4'h0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL rst_stall_clear: got v=%b b=%b mc=%b ill=%b ctrl=%h err=%0d want all 0",
                               out_valid, busy, multi_cycle, illegal, alu_ctrl, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        in_valid = 1'b1; ALUOp = 2'b00; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0001) begin
            n_fail++; $display("FAIL rst_stall_op: got v=%b %b want v=1 0001", out_valid, alu_ctrl);
        end
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            ALUOp     = 2'($urandom_range(0, 3));
            Funct     = ($urandom_range(0, 3) != 0) ? 6'(32 + $urandom_range(0, 11)) : 6'($urandom);
            OpCode    = ($urandom_range(0, 3) != 0) ? 6'(48 + $urandom_range(0, 5)) : 6'($urandom);
            #1;
            n_tests++; if (in_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rnd_in_ready @%0d: got %b want %b", cyc, in_ready, exp_ready());
            end
            n_tests++; if (out_valid !== m_full || busy !== (m_stall > 0) || int'(err_count) != m_err) begin
                n_fail++; $display("FAIL rnd_status @%0d: got v=%b b=%b err=%0d want v=%b b=%b err=%0d",
                                   cyc, out_valid, busy, err_count, m_full, (m_stall > 0), m_err);
            end
            if (m_full) begin
                n_tests++; if (alu_ctrl !== m_ctrl || multi_cycle !== m_mc || illegal !== m_ill) begin
                    n_fail++; $display("FAIL rnd_op @%0d: got %b mc=%b ill=%b want %b mc=%b ill=%b",
                                       cyc, alu_ctrl, multi_cycle, illegal, m_ctrl, m_mc, m_ill);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_multi_cycle();
        test_illegal();
        test_reset_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
